// File: rtl/msff_pkg.sv
// Shared constants and types for the master/slave flip-flop built from two
// transparent latches.
package msff_pkg;

    localparam int   MSFF_WIDTH   = 1;
    localparam logic MSFF_RST_BIT = 1'b0;

    // Level of the enable input at which a latch is transparent.
    typedef enum logic {
        LATCH_ACTIVE_HIGH = 1'b0,
        LATCH_ACTIVE_LOW  = 1'b1
    } latch_pol_e;

endpackage

// File: rtl/master_slave_dff_d_latch.sv
// Level-sensitive transparent latch bank with asynchronous reset to RST_VAL.
// Enable polarity is selected by EN_POL.
module d_latch
    import msff_pkg::*;
#(
    parameter int               WIDTH   = MSFF_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{MSFF_RST_BIT}},
    parameter latch_pol_e       EN_POL  = LATCH_ACTIVE_HIGH
) (
    input  logic             en,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic open_w;

    assign open_w = (EN_POL == LATCH_ACTIVE_HIGH) ? en : ~en;

    // Reset wins over the enable, so the latch is forced regardless of clk.
    always_latch begin
        if (rst) begin
            q <= RST_VAL;
        end else if (open_w) begin
            q <= d;
        end
    end

endmodule

// File: rtl/master_slave_dff.sv
// Rising-edge D flip-flop bank made from a low-transparent master latch and a
// high-transparent slave latch. Define MSFF_SCAN_EN to add a scan input mux.
module master_slave_dff
    import msff_pkg::*;
#(
    parameter int               WIDTH   = MSFF_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{MSFF_RST_BIT}}
) (
    input  logic             clk,
    input  logic             rst,
`ifdef MSFF_SCAN_EN
    input  logic             scan_en,
    input  logic [WIDTH-1:0] scan_in,
    output logic [WIDTH-1:0] scan_out,
`endif
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic [WIDTH-1:0] master_q
);

    logic [WIDTH-1:0] master_d;

`ifdef MSFF_SCAN_EN
    assign master_d = scan_en ? scan_in : d;
    assign scan_out = q;
`else
    assign master_d = d;
`endif

    d_latch #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL),
        .EN_POL  (LATCH_ACTIVE_LOW)
    ) u_master (
        .en  (clk),
        .rst (rst),
        .d   (master_d),
        .q   (master_q)
    );

    // Slave opens as the master closes, so q only moves at the rising edge.
    d_latch #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL),
        .EN_POL  (LATCH_ACTIVE_HIGH)
    ) u_slave (
        .en  (clk),
        .rst (rst),
        .d   (master_q),
        .q   (q)
    );

    assign q_n = ~q;

endmodule

// File: tb/tb_master_slave_dff.sv
// Directed self-checking bench for master_slave_dff at WIDTH=8; scan checks are
// included when MSFF_SCAN_EN is defined.
module tb_master_slave_dff;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic [W-1:0] q_n;
    logic [W-1:0] master_q;
`ifdef MSFF_SCAN_EN
    logic         scan_en;
    logic [W-1:0] scan_in;
    logic [W-1:0] scan_out;
`endif

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];

    master_slave_dff #(
        .WIDTH   (W),
        .RST_VAL ('0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef MSFF_SCAN_EN
        .scan_en  (scan_en),
        .scan_in  (scan_in),
        .scan_out (scan_out),
`endif
        .d        (d),
        .q        (q),
        .q_n      (q_n),
        .master_q (master_q)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic drive_d(input logic [W-1:0] val);
        d = val;
    endtask

    task automatic after_rise();
        @(posedge clk);
        #1;
    endtask

    task automatic after_fall();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_d(8'hFF);
        #1;
        total++; if (q !== 8'h00) begin bad++; $display("FAIL reset_clk0_q: got %h want 00", q); end
        total++; if (q_n !== 8'hFF) begin bad++; $display("FAIL reset_clk0_qn: got %h want ff", q_n); end
        total++; if (master_q !== 8'h00) begin bad++; $display("FAIL reset_clk0_mq: got %h want 00", master_q); end
        after_rise();
        total++; if (q !== 8'h00 || master_q !== 8'h00) begin bad++; $display("FAIL reset_clk1: got q=%h mq=%h want 00/00", q, master_q); end
        drive_d(8'h00);
        rst = 1'b0;
        #1;
        total++; if (q !== 8'h00 || master_q !== 8'h00) begin bad++; $display("FAIL release_clk1: got q=%h mq=%h want 00/00", q, master_q); end
        // fresh assertion while clk is low, with d high
        after_fall();
        drive_d(8'hFF);
        #1;
        rst = 1'b1;
        #1;
        total++; if (q !== 8'h00 || q_n !== 8'hFF || master_q !== 8'h00) begin bad++; $display("FAIL reset_clk0_pulse: got q=%h qn=%h mq=%h want 00/ff/00", q, q_n, master_q); end
        drive_d(8'h00);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            after_rise();
            total++; if (q !== 8'h00) begin bad++; $display("FAIL post_release_edge%0d: got %h want 00", i, q); end
        end
    endtask

    task automatic test_single_pulse();
        after_fall();
        drive_d(8'h00);
        after_rise();
        total++; if (q !== 8'h00) begin bad++; $display("FAIL pulse_edge1: got %h want 00", q); end
        after_rise();
        total++; if (q !== 8'h00) begin bad++; $display("FAIL pulse_edge2: got %h want 00", q); end
        drive_d(8'hFF);
        after_rise();
        total++; if (q !== 8'hFF) begin bad++; $display("FAIL pulse_edge3: got %h want ff", q); end
        drive_d(8'h00);
        after_rise();
        total++; if (q !== 8'h00) begin bad++; $display("FAIL pulse_edge4: got %h want 00", q); end
    endtask

    task automatic test_hold_high();
        after_rise();
        drive_d(8'hFF);
        #1;
        total++; if (q !== 8'h00 || master_q !== 8'h00) begin bad++; $display("FAIL hold_high_d1: got q=%h mq=%h want 00/00", q, master_q); end
        drive_d(8'h00);
        #1;
        total++; if (q !== 8'h00 || master_q !== 8'h00) begin bad++; $display("FAIL hold_high_d0: got q=%h mq=%h want 00/00", q, master_q); end
    endtask

    task automatic test_master_transparency();
        after_fall();
        drive_d(8'hFF);
        #1;
        total++; if (master_q !== 8'hFF) begin bad++; $display("FAIL master_follow: got %h want ff", master_q); end
        total++; if (q !== 8'h00) begin bad++; $display("FAIL slave_hold_low: got %h want 00", q); end
        after_rise();
        total++; if (q !== 8'hFF) begin bad++; $display("FAIL master_capture: got %h want ff", q); end
    endtask

    task automatic test_mid_cycle_reset();
        // q is ff and clk is high on entry; d stays ff
        rst = 1'b1;
        #1;
        total++; if (q !== 8'h00 || q_n !== 8'hFF || master_q !== 8'h00) begin bad++; $display("FAIL midrst_assert: got q=%h qn=%h mq=%h want 00/ff/00", q, q_n, master_q); end
        rst = 1'b0;
        #1;
        total++; if (q !== 8'h00) begin bad++; $display("FAIL midrst_release_clk1: got %h want 00", q); end
        after_fall();
        total++; if (q !== 8'h00 || master_q !== 8'hFF) begin bad++; $display("FAIL midrst_clk0: got q=%h mq=%h want 00/ff", q, master_q); end
        after_rise();
        total++; if (q !== 8'hFF) begin bad++; $display("FAIL midrst_recapture: got %h want ff", q); end
    endtask

    task automatic test_width();
        after_fall();
        drive_d(8'hA5);
        after_rise();
        total++; if (q !== 8'hA5) begin bad++; $display("FAIL width_q: got %h want a5", q); end
        total++; if (q_n !== 8'h5A) begin bad++; $display("FAIL width_qn: got %h want 5a", q_n); end
    endtask

`ifdef MSFF_SCAN_EN
    task automatic test_scan();
        after_fall();
        scan_en = 1'b1;
        scan_in = 8'h3C;
        drive_d(8'hFF);
        after_rise();
        total++; if (q !== 8'h3C || scan_out !== 8'h3C) begin bad++; $display("FAIL scan_capture: got q=%h so=%h want 3c/3c", q, scan_out); end
        after_fall();
        scan_en = 1'b0;
        after_rise();
        total++; if (q !== 8'hFF) begin bad++; $display("FAIL scan_off: got %h want ff", q); end
    endtask
`endif

    task automatic test_back_to_back();
        logic [W-1:0] vec [8];
        logic [W-1:0] want;
        vec = '{8'h00, 8'hFF, 8'hA5, 8'h5A, 8'h01, 8'h80, 8'h3C, 8'hC3};
        for (int i = 0; i < 8; i++) begin
            after_fall();
            drive_d(vec[i]);
            exp_q.push_back(vec[i]);
            after_rise();
            want = exp_q.pop_front();
            total++; if (q !== want || q_n !== ~want) begin bad++; $display("FAIL b2b_%0d: got q=%h qn=%h want %h/%h", i, q, q_n, want, ~want); end
        end
    endtask

    initial begin
        rst = 1'b1;
        d   = '0;
`ifdef MSFF_SCAN_EN
        scan_en = 1'b0;
        scan_in = '0;
`endif
        test_reset();
        test_single_pulse();
        test_hold_high();
        test_master_transparency();
        test_mid_cycle_reset();
        test_width();
`ifdef MSFF_SCAN_EN
        test_scan();
`endif
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
